// File: rtl/sum3_block_accumulator.sv
// Accumulates BLOCK_LEN valid/ready samples of the adder-tree sum3 and presents the block total.
// Build option: define ACC_SAT_EN to clamp the total at 2^ACC_W-1 on overflow instead of wrapping.
module sum3_block_accumulator #(
    parameter int IN_W      = 10,
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    // state | meaning
    // IDLE  | no sample of the current block taken yet
    // ACCUM | 1..BLOCK_LEN-1 samples summed
    // HOLD  | block complete, waiting for the consumer
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam int EXT_W = ACC_W + 1;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [EXT_W-1:0]   in_ext;
    logic [EXT_W-1:0]   sum_ext;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic               xfer;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    assign accept  = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;
    assign in_ext  = EXT_W'(in_sum);
    assign sum_ext = {1'b0, acc_q} + in_ext;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = in_ext[ACC_W-1:0];
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = (BLOCK_LEN == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
`ifdef ACC_SAT_EN
                        // once clamped, the total stays pinned at full scale for the block
                        if (ovf_q || sum_ext[ACC_W])
                            acc_d = '1;
                        else
                            acc_d = sum_ext[ACC_W-1:0];
`else
                        acc_d = sum_ext[ACC_W-1:0];
`endif
                        ovf_d = ovf_q | sum_ext[ACC_W];
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(BLOCK_LEN))
                            state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
